// File: rtl/switch_bounce_gen.sv
// Emulates a mechanical switch: each change of cmd_level produces a burst of
// contact glitches on sw, then a stable settle window, then a done_tick.
module switch_bounce_gen #(
  parameter bit         RANDOM       = 1'b1,
  parameter int         FIXED_PULSES = 2,
  parameter int         FIXED_HOLD   = 3,
  parameter int         SETTLE_CYC   = 8,
  parameter logic [7:0] SEED         = 8'hA5
) (
  input  logic clk,
  input  logic reset,
  input  logic cmd_level,
  output logic sw,
  output logic busy,
  output logic done_tick
);

  localparam logic [7:0] LFSR_INIT = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam int SET_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC);
  localparam logic [2:0] FIXED_TOG = 3'(2 * FIXED_PULSES);
  localparam logic [3:0] FIXED_HOLD_L = 4'(FIXED_HOLD);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             level_reg, level_nxt;
  logic             target, target_nxt;
  logic [3:0]       hold_cnt, hold_nxt;
  logic [2:0]       tog_left, tog_nxt;
  logic [SET_W-1:0] set_cnt, set_nxt;
  logic [7:0]       lfsr, lfsr_nxt;
  logic             sw_nxt, busy_nxt, done_nxt;
  logic [3:0]       hold_load;
  logic [2:0]       tog_load;

  // x^8+x^6+x^5+x^4+1, free-running in every state
  assign lfsr_nxt  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign hold_load = RANDOM ? ({1'b0, lfsr[4:2]} + 4'd1) : FIXED_HOLD_L;
  // Two toggles per glitch pulse keeps the count even, so sw lands on target.
  assign tog_load  = RANDOM ? {lfsr[1:0], 1'b0} : FIXED_TOG;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_nxt  = state;
    level_nxt  = level_reg;
    target_nxt = target;
    hold_nxt   = hold_cnt;
    tog_nxt    = tog_left;
    set_nxt    = set_cnt;
    sw_nxt     = sw;
    busy_nxt   = busy;
    done_nxt   = 1'b0;

    case (state)
      IDLE: begin
        sw_nxt   = level_reg;
        busy_nxt = 1'b0;
        if (cmd_level != level_reg) begin
          target_nxt = cmd_level;
          sw_nxt     = cmd_level;
          busy_nxt   = 1'b1;
          hold_nxt   = hold_load;
          tog_nxt    = tog_load;
          state_nxt  = BOUNCE;
        end
      end
      BOUNCE: begin
        if (hold_cnt <= 4'd1) begin
          if (tog_left != 3'd0) begin
            sw_nxt   = ~sw;
            tog_nxt  = tog_left - 3'd1;
            hold_nxt = hold_load;
          end else begin
            set_nxt   = SETTLE_LOAD;
            state_nxt = SETTLE;
          end
        end else begin
          hold_nxt = hold_cnt - 4'd1;
        end
      end
      SETTLE: begin
        sw_nxt = target;
        if (set_cnt <= SET_W'(1)) begin
          level_nxt = target;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          set_nxt = set_cnt - SET_W'(1);
        end
      end
      default: begin
        sw_nxt    = level_reg;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      level_reg <= 1'b0;
      target    <= 1'b0;
      hold_cnt  <= 4'd0;
      tog_left  <= 3'd0;
      set_cnt   <= '0;
      lfsr      <= LFSR_INIT;
      sw        <= 1'b0;
      busy      <= 1'b0;
      done_tick <= 1'b0;
    end else begin
      state     <= state_nxt;
      level_reg <= level_nxt;
      target    <= target_nxt;
      hold_cnt  <= hold_nxt;
      tog_left  <= tog_nxt;
      set_cnt   <= set_nxt;
      lfsr      <= lfsr_nxt;
      sw        <= sw_nxt;
      busy      <= busy_nxt;
      done_tick <= done_nxt;
    end
  end

endmodule

// File: doc/switch_bounce_gen.md
SWITCH_BOUNCE_GEN -- requirements
Module: switch_bounce_gen

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameters (name, default, meaning), one per line:
- RANDOM, 1: 1 = glitch count and hold times come from the LFSR; 0 = they come from the FIXED_* parameters.
- FIXED_PULSES, 2: glitch pulses per transition when RANDOM=0; range 0..3.
- FIXED_HOLD, 3: cycles per sw segment when RANDOM=0; range 1..8.
- SETTLE_CYC, 8: stable cycles after the bounce phase; range >=1.
- SEED, 8'hA5: LFSR reset value; 0 is replaced by 8'h01.
REQ-003 Ports (name  direction  width  meaning), one per line:
- clk  input  1  clock; all registers update on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_level  input  1  requested clean switch level.
- sw  output  1  emulated bouncy switch contact; registered.
- busy  output  1  high while a transition sequence runs; registered.
- done_tick  output  1  one-cycle pulse when a sequence completes; registered.

Function
REQ-004 SHALL implement an FSM with states IDLE, BOUNCE and SETTLE, plus internal registers level_reg, target, hold_cnt (4b), tog_left (3b), set_cnt and lfsr (8b).
REQ-005 The LFSR SHALL advance every cycle in all states: shift left, bit0 = b7^b5^b4^b3 (x^8+x^6+x^5+x^4+1).
REQ-006 In IDLE, sw SHALL equal level_reg, and cmd_level SHALL be sampled only in IDLE.
REQ-007 IDLE with cmd_level != level_reg: next edge sets target=cmd_level, sw=cmd_level, busy=1, state=BOUNCE.
- On the same edge, pulses P = lfsr[1:0] (RANDOM=1) or FIXED_PULSES; tog_left = 2*P.
- hold_cnt = lfsr[4:2]+1 (RANDOM=1) or FIXED_HOLD.
REQ-008 BOUNCE: hold_cnt decrements each cycle; on expiry (hold_cnt==1):
- tog_left!=0: invert sw, decrement tog_left, reload hold_cnt per REQ-007.
- tog_left==0: go to SETTLE with set_cnt=SETTLE_CYC; sw unchanged (==target).
REQ-009 tog_left is always even, so sw SHALL equal target whenever SETTLE is entered.
REQ-010 SETTLE: sw held at target, set_cnt decrements; on expiry: level_reg=target, done_tick=1 for exactly one cycle, busy=0, state=IDLE, all on the same edge.
REQ-011 cmd_level changes during BOUNCE/SETTLE SHALL be ignored. If cmd_level still differs from level_reg in IDLE, a new sequence starts on the next edge.
REQ-012 Total busy duration = (2P+1)*hold segments + SETTLE_CYC cycles; glitch segment lengths are 1..8 cycles each.
REQ-013 Illegal FSM encodings SHALL recover to IDLE on the next edge with sw=level_reg.

Reset
REQ-014 While reset is asserted, outputs SHALL be forced immediately (asynchronously) to sw=0, busy=0, done_tick=0.
REQ-015 While reset is asserted, internal state SHALL be forced to state=IDLE, level_reg=0, target=0, counters=0, lfsr=SEED (or 8'h01 if SEED=0).
REQ-016 Reset asserted mid-BOUNCE or mid-SETTLE SHALL abort the sequence without a done_tick. After release, if cmd_level=1, a new sequence starts on the first edge.

Verification
REQ-017 RANDOM=0, P=2, HOLD=3, SETTLE=8; cmd_level 0->1 in IDLE -> sw = 1 at E1, 0 at E4, 1 at E7, 0 at E10, 1 at E13 and held; done_tick=1 and busy=0 at E24 only.
REQ-018 RANDOM=0, FIXED_PULSES=0, HOLD=3, SETTLE=8; cmd_level 1->0 -> sw=0 from E1 with no glitches; done_tick at E12.
REQ-019 Toggle cmd_level 1->0->1 during BOUNCE of a 0->1 sequence -> no effect on sw; sequence completes with level 1; no new sequence starts.
REQ-020 Assert reset at E8 of the REQ-017 sequence -> sw=0 and busy=0 immediately; no done_tick; with cmd_level=1 after release, the sequence restarts from E1.
REQ-021 RANDOM=1, SEED=8'hA5, 32 alternating transitions -> glitch counts 0..3 all occur; every segment is 1..8 cycles; sw==target at every done_tick.
REQ-022 Drive sw into the team debounce block -> its db_level settles to cmd_level, with exactly one db_tick per 0->1 sequence.
